// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - DCM reset/lock sequencer producing a clean synchronous system reset
// Optional LOCK_LOSS_RECOVER_EN: rerun the full DCM sequence when lock drops in RUN.
module clk_rst_seq #(
    parameter int unsigned RST_PULSE    = 4,
    parameter int unsigned LOCK_TIMEOUT = 1000,
    parameter int unsigned HOLD_CYCLES  = 16
) (
    input  logic       clk_in,
    input  logic       global_reset,
    input  logic       locked,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    localparam logic [1:0] RESET_DCM = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [15:0] PULSE_LAST   = 16'(RST_PULSE - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);

    logic        sync_meta;
    logic        locked_s;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    logic        lost_nxt;

    // locked comes from the DCM's own domain; only locked_s may steer the FSM
    always_ff @(posedge clk_in or posedge global_reset) begin
        if (global_reset) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= locked;
            locked_s  <= sync_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost;
        case (state)
            RESET_DCM: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 16'd0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = RESET_DCM;
                    cnt_nxt   = 16'd0;
                    if (retry_cnt != 4'd15) begin
                        retry_nxt = retry_cnt + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RUN: begin
                cnt_nxt = 16'd0;
                if (!locked_s) begin
                    lost_nxt = 1'b1;
`ifdef LOCK_LOSS_RECOVER_EN
                    state_nxt = RESET_DCM;
`endif
                end
            end
            default: begin
                state_nxt = RESET_DCM;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs decode state_nxt so they switch on the same edge as the state
    always_ff @(posedge clk_in or posedge global_reset) begin
        if (global_reset) begin
            state     <= RESET_DCM;
            cnt       <= 16'd0;
            dcm_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= 4'd0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dcm_rst   <= (state_nxt == RESET_DCM);
            sys_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            retry_cnt <= retry_nxt;
            lock_lost <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - randomized self-checking bench for clk_rst_seq against a duration-based model
module tb_clk_rst_seq;

    localparam int RST_PULSE    = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int HOLD_CYCLES  = 8;

    logic       clk = 1'b0;
    logic       global_reset = 1'b1;
    logic       locked = 1'b0;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_cnt;
    logic       lock_lost;

    int checks = 0;
    int failures = 0;

    clk_rst_seq #(
        .RST_PULSE   (RST_PULSE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_in      (clk),
        .global_reset(global_reset),
        .locked      (locked),
        .dcm_rst     (dcm_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .retry_cnt   (retry_cnt),
        .lock_lost   (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: phase (0 pulse, 1 wait, 2 hold, 3 run) and edges spent in it
    int ph = 0;
    int el = 0;
    int m_retry = 0;
    bit m_lost = 1'b0;
    bit h0 = 1'b0;
    bit h1 = 1'b0;
    bit m_ls;

    always @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            ph = 0; el = 0; m_retry = 0; m_lost = 1'b0; h0 = 1'b0; h1 = 1'b0;
        end else begin
            m_ls = h1;
            h1 = h0;
            h0 = locked;
            case (ph)
                0: begin
                    el++;
                    if (el == RST_PULSE) begin ph = 1; el = 0; end
                end
                1: begin
                    if (m_ls) begin
                        ph = 2; el = 0;
                    end else begin
                        el++;
                        if (el == LOCK_TIMEOUT) begin
                            ph = 0; el = 0;
                            if (m_retry < 15) m_retry++;
                        end
                    end
                end
                2: begin
                    if (!m_ls) begin
                        ph = 1; el = 0;
                    end else begin
                        el++;
                        if (el == HOLD_CYCLES) begin ph = 3; el = 0; end
                    end
                end
                default: begin
                    if (!m_ls) begin
                        m_lost = 1'b1;
`ifdef LOCK_LOSS_RECOVER_EN
                        ph = 0; el = 0;
`endif
                    end
                end
            endcase
        end
    end

    int pulses = 0;
    logic prev_dcm = 1'b1;

    always @(negedge clk) begin
        check("dcm_rst", dcm_rst, int'(ph == 0));
        check("sys_rst", sys_rst, int'(ph != 3));
        check("ready", ready, int'(ph == 3));
        check("retry_cnt", retry_cnt, m_retry);
        check("lock_lost", lock_lost, m_lost);
        if (dcm_rst && !prev_dcm) pulses++;
        prev_dcm = dcm_rst;
    end

    task automatic release_reset(input logic lvl);
        @(negedge clk);
        #1 locked = lvl;
        global_reset = 1'b1;
        @(negedge clk);
        #1 global_reset = 1'b0;
        pulses = 0;
    endtask

    task automatic edges_until_run(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sys_rst && n < 300);
    endtask

    initial begin
        int n;
        logic lvl;

        // Lock tied high from release
        release_reset(1'b1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dcm_rst && n < 100);
        check("initial_pulse_len", n, 4);
        edges_until_run(n);
        check("ready_locked_high", ready, 1);
        check("retry_locked_high", retry_cnt, 0);

        // Two timeouts, lock arrives while the third pulse is active
        release_reset(1'b0);
        repeat (50) @(negedge clk);
        #1 locked = 1'b1;
        edges_until_run(n);
        check("retry_two_timeouts", retry_cnt, 2);
        check("extra_pulses", pulses, 2);
        check("ready_after_retry", ready, 1);

        // Glitch during HOLD restarts the hold count
        release_reset(1'b0);
        repeat (6) @(negedge clk);
        #1 locked = 1'b1;
        edges_until_run(n);
        check("first_lock_latency", n - 1, 10);
        release_reset(1'b0);
        repeat (6) @(negedge clk);
        #1 locked = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1 locked = 1'b0;
        repeat (2) @(negedge clk);
        #1 locked = 1'b1;
        edges_until_run(n);
        check("relock_latency", n - 1, 10);

        // Lock loss in RUN
        @(negedge clk);
        #1 locked = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("lock_lost_early", lock_lost, 0);
        @(posedge clk);
        #1 check("lock_lost_set", lock_lost, 1);
`ifdef LOCK_LOSS_RECOVER_EN
        check("recover_sys_rst", sys_rst, 1);
        check("recover_dcm_rst", dcm_rst, 1);
`else
        check("norecover_sys_rst", sys_rst, 0);
        check("norecover_ready", ready, 1);
`endif
        repeat (10) @(negedge clk);
        #1 locked = 1'b1;
        repeat (30) @(negedge clk);
        check("lock_lost_sticky", lock_lost, 1);

        // 17 timeouts saturate retry_cnt
        release_reset(1'b0);
        repeat (17 * (RST_PULSE + LOCK_TIMEOUT) + 10) @(negedge clk);
        check("retry_saturated", retry_cnt, 15);

        // Asynchronous reset in the middle of HOLD
        #1 locked = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 global_reset = 1'b1;
        #1;
        check("async_dcm_rst", dcm_rst, 1);
        check("async_sys_rst", sys_rst, 1);
        check("async_ready", ready, 0);
        check("async_retry", retry_cnt, 0);
        check("async_lock_lost", lock_lost, 0);
        @(negedge clk);
        #1 global_reset = 1'b0;

        // Randomized lock behaviour with sub-cycle glitches and resets
        for (int s = 0; s < 150; s++) begin
            lvl = ($urandom_range(0, 3) != 0);
            for (int d = 0; d < int'($urandom_range(1, 30)); d++) begin
                @(negedge clk);
                #1 locked = lvl;
                if ($urandom_range(0, 9) == 0) begin
                    #2 locked = ~lvl;
                    #1 locked = lvl;
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                #3 global_reset = 1'b1;
                @(negedge clk);
                #3 global_reset = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
